ibex_ex_unit_iter: RTL

IBEX_EX_UNIT_ITER -- requirements
Module: ibex_ex_unit_iter

---
 rtl/ibex_ex_pkg.sv | 34 +++
 rtl/ibex_ex_unit_iter_if.sv | 33 +++
 rtl/ibex_ex_iter_muldiv.sv | 75 +++++++
 rtl/ibex_ex_unit_iter.sv | 124 ++++++++++++
 4 files changed

// File: rtl/ibex_ex_pkg.sv
// Shared types for the iterative execute unit: operator encoding and FSM states.
// IBEX_EX_DIV_EN adds DIVU/REMU to the set of iterative operators.
package ibex_ex_pkg;

  typedef enum logic [3:0] {
    OpAdd   = 4'd0,
    OpSub   = 4'd1,
    OpAnd   = 4'd2,
    OpOr    = 4'd3,
    OpXor   = 4'd4,
    OpSlt   = 4'd5,
    OpSltu  = 4'd6,
    OpEq    = 4'd7,
    OpMul   = 4'd8,
    OpMulhu = 4'd9,
    OpDivu  = 4'd10,
    OpRemu  = 4'd11
  } op_e;

  typedef enum logic [1:0] {
    StIdle,
    StIter,
    StDone
  } state_e;

  function automatic logic is_iter_op(op_e op);
`ifdef IBEX_EX_DIV_EN
    return (op == OpMul) || (op == OpMulhu) || (op == OpDivu) || (op == OpRemu);
`else
    return (op == OpMul) || (op == OpMulhu);
`endif
  endfunction

endpackage

// File: rtl/ibex_ex_unit_iter_if.sv
// Request/result handshake bundle of the iterative execute unit.
interface ibex_ex_unit_iter_if #(
  parameter int unsigned WIDTH = 32
);
  logic             op_valid_i;
  logic             op_ready_o;
  logic [3:0]       operator_i;
  logic [WIDTH-1:0] operand_a_i;
  logic [WIDTH-1:0] operand_b_i;
  logic [WIDTH-1:0] bt_a_operand_i;
  logic [WIDTH-1:0] bt_b_operand_i;
  logic             result_valid_o;
  logic             result_ready_i;
  logic [WIDTH-1:0] result_o;
  logic             branch_decision_o;
  logic [WIDTH-1:0] branch_target_o;
  logic             illegal_o;
  logic             busy_o;

  modport slave (
    input  op_valid_i, operator_i, operand_a_i, operand_b_i, bt_a_operand_i, bt_b_operand_i,
           result_ready_i,
    output op_ready_o, result_valid_o, result_o, branch_decision_o, branch_target_o, illegal_o,
           busy_o
  );

  modport master (
    output op_valid_i, operator_i, operand_a_i, operand_b_i, bt_a_operand_i, bt_b_operand_i,
           result_ready_i,
    input  op_ready_o, result_valid_o, result_o, branch_decision_o, branch_target_o, illegal_o,
           busy_o
  );
endinterface

// File: rtl/ibex_ex_iter_muldiv.sv
// One-bit-per-step unsigned shift-add multiplier and (with IBEX_EX_DIV_EN) restoring divider.
// o_result is the post-step value so the caller can register it on the final step.
module ibex_ex_iter_muldiv
  import ibex_ex_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             i_start,
  input  logic             i_step,
  input  logic             i_last,
  input  op_e              i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result
);

  logic [WIDTH-1:0] r_hi, r_lo, r_a;
  op_e              r_op;
  logic [WIDTH-1:0] w_hi_d, w_lo_d;
  logic [WIDTH:0]   w_sum;
  logic             w_is_mul;
`ifdef IBEX_EX_DIV_EN
  logic [WIDTH:0]   w_shift, w_trial;
`endif

  assign w_is_mul = (i_op == OpMul) || (i_op == OpMulhu);

  always_comb begin
    // Multiply: r_hi accumulates, r_lo shifts out multiplier bits and in product bits.
    w_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : '0);
    w_hi_d = w_sum[WIDTH:1];
    w_lo_d = {w_sum[0], r_lo[WIDTH-1:1]};
`ifdef IBEX_EX_DIV_EN
    w_shift = {r_hi, r_lo[WIDTH-1]};
    w_trial = w_shift - {1'b0, r_a};
    if ((r_op == OpDivu) || (r_op == OpRemu)) begin
      if (w_trial[WIDTH]) begin
        w_hi_d = w_shift[WIDTH-1:0];
        w_lo_d = {r_lo[WIDTH-2:0], 1'b0};
      end else begin
        w_hi_d = w_trial[WIDTH-1:0];
        w_lo_d = {r_lo[WIDTH-2:0], 1'b1};
      end
    end
`endif
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_hi <= '0;
      r_lo <= '0;
      r_a  <= '0;
      r_op <= OpAdd;
    end else if (i_start) begin
      r_hi <= '0;
      r_lo <= w_is_mul ? i_b : i_a;
      r_a  <= w_is_mul ? i_a : i_b;
      r_op <= i_op;
    end else if (i_step) begin
      r_hi <= w_hi_d;
      r_lo <= w_lo_d;
    end
  end

  assign o_done = i_step & i_last;
`ifdef IBEX_EX_DIV_EN
  assign o_result = ((r_op == OpMul) || (r_op == OpDivu)) ? w_lo_d : w_hi_d;
`else
  assign o_result = (r_op == OpMul) ? w_lo_d : w_hi_d;
`endif

endmodule

// File: rtl/ibex_ex_unit_iter.sv
// Execute unit: single-cycle ALU plus iterative mul/div behind an IDLE/ITER/DONE handshake FSM.
// Define IBEX_EX_DIV_EN to build the divider; otherwise DIVU/REMU report illegal.
module ibex_ex_unit_iter
  import ibex_ex_pkg::*;
#(
  parameter int unsigned WIDTH           = 32,
  parameter bit          BranchTargetALU = 1'b0
) (
  input logic                clk_i,
  input logic                rst_i,
  ibex_ex_unit_iter_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  state_e           r_state, w_state_d;
  logic [CntW-1:0]  r_count;
  logic [WIDTH-1:0] r_result, w_alu_result, w_md_result, w_a, w_b;
  logic             r_branch, r_illegal, w_alu_branch, w_alu_illegal;
  logic             w_accept, w_iter_op, w_div_zero, w_last, w_md_done;
  op_e              w_op;

  assign w_op     = op_e'(bus.operator_i);
  assign w_a      = bus.operand_a_i;
  assign w_b      = bus.operand_b_i;
  assign w_accept = bus.op_valid_i & (r_state == StIdle);
  assign w_last   = (r_count == CntW'(WIDTH - 1));
`ifdef IBEX_EX_DIV_EN
  assign w_div_zero = ((w_op == OpDivu) || (w_op == OpRemu)) && (w_b == '0);
`else
  assign w_div_zero = 1'b0;
`endif
  assign w_iter_op = is_iter_op(w_op) && !w_div_zero;

  always_comb begin
    w_alu_result  = '0;
    w_alu_branch  = 1'b0;
    w_alu_illegal = 1'b0;
    case (w_op)
      OpAdd:  w_alu_result = w_a + w_b;
      OpSub:  w_alu_result = w_a - w_b;
      OpAnd:  w_alu_result = w_a & w_b;
      OpOr:   w_alu_result = w_a | w_b;
      OpXor:  w_alu_result = w_a ^ w_b;
      OpSlt:  w_alu_branch = $signed(w_a) < $signed(w_b);
      OpSltu: w_alu_branch = w_a < w_b;
      OpEq:   w_alu_branch = w_a == w_b;
      OpMul, OpMulhu: w_alu_result = '0;
`ifdef IBEX_EX_DIV_EN
      // Only reaches the result register on divide by zero.
      OpDivu: w_alu_result = '1;
      OpRemu: w_alu_result = w_a;
`endif
      default: w_alu_illegal = 1'b1;
    endcase
    if ((w_op == OpSlt) || (w_op == OpSltu) || (w_op == OpEq)) begin
      w_alu_result = {{(WIDTH - 1){1'b0}}, w_alu_branch};
    end
  end

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle: if (w_accept) w_state_d = w_iter_op ? StIter : StDone;
      StIter: if (w_last) w_state_d = StDone;
      StDone: if (bus.result_ready_i) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= StIdle;
      r_count   <= '0;
      r_result  <= '0;
      r_branch  <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_state_d;
      if (w_accept) begin
        r_count   <= '0;
        r_result  <= w_alu_result;
        r_branch  <= w_alu_branch;
        r_illegal <= w_alu_illegal;
      end else if (r_state == StIter) begin
        r_count <= r_count + CntW'(1);
        if (w_md_done) r_result <= w_md_result;
      end else if ((r_state == StDone) && bus.result_ready_i) begin
        r_result  <= '0;
        r_branch  <= 1'b0;
        r_illegal <= 1'b0;
      end
    end
  end

  ibex_ex_iter_muldiv #(
    .WIDTH(WIDTH)
  ) u_muldiv (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_start (w_accept & w_iter_op),
    .i_step  (r_state == StIter),
    .i_last  (w_last),
    .i_op    (w_op),
    .i_a     (w_a),
    .i_b     (w_b),
    .o_done  (w_md_done),
    .o_result(w_md_result)
  );

  if (BranchTargetALU) begin : g_bt_alu
    assign bus.branch_target_o = bus.bt_a_operand_i + bus.bt_b_operand_i;
  end else begin : g_bt_shared
    assign bus.branch_target_o = w_a + w_b;
  end

  assign bus.op_ready_o        = (r_state == StIdle);
  assign bus.result_valid_o    = (r_state == StDone);
  assign bus.busy_o            = (r_state != StIdle);
  assign bus.result_o          = r_result;
  assign bus.branch_decision_o = r_branch;
  assign bus.illegal_o         = r_illegal;

endmodule
